sblk_act_feeder: RTL and testbench

Activation transmitter for a row of superblocks: it is the sending end of the per-row `act_data_in` / `act_data_in_vld` / `act_data_in_req` interface. A host stream pushes activation words, each addressed to one row or broadcast to all rows, into per-row FIFOs. The block drains each FIFO toward its superblock one beat per request cycle, up to a programmed number of beats per frame. It sits between the activation buffer/controller and the superblock row, in the `clk_l` domain.

---
 rtl/sblk_act_feeder_if.sv | 28 ++
 rtl/sblk_act_feeder.sv | 167 ++++++++++++++++
 tb/tb_sblk_act_feeder.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/sblk_act_feeder_if.sv
// Host push stream and per-row activation stream of the superblock-row feeder.
interface sblk_act_feeder_if #(
  parameter int unsigned N_ROW   = 4,
  parameter int unsigned WID_ACT = 16,
  parameter int unsigned WID_ROW = (N_ROW > 1) ? $clog2(N_ROW) : 1
);
  localparam int unsigned BEAT_W = 2 * WID_ACT;

  logic [BEAT_W-1:0]       src_data;
  logic [WID_ROW-1:0]      src_row;
  logic                    src_bcast;
  logic                    src_vld;
  logic                    src_rdy;
  logic [BEAT_W*N_ROW-1:0] act_data_in;
  logic [N_ROW-1:0]        act_data_in_vld;
  logic [N_ROW-1:0]        act_data_in_req;

  // master: the feeder itself; slave: host plus superblock row
  modport master (
    input  src_data, src_row, src_bcast, src_vld, act_data_in_req,
    output src_rdy, act_data_in, act_data_in_vld
  );

  modport slave (
    output src_data, src_row, src_bcast, src_vld, act_data_in_req,
    input  src_rdy, act_data_in, act_data_in_vld
  );
endinterface

// File: rtl/sblk_act_feeder.sv
// Activation transmitter: host words land in per-row FIFOs and are drained one
// beat per request cycle toward each superblock row, up to n_beats per frame.
module sblk_act_feeder #(
  parameter int unsigned N_ROW      = 4,
  parameter int unsigned WID_ACT    = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned WID_CNT    = 10,
  // may be set wider than needed so hosts can present out-of-range rows
  parameter int unsigned WID_ROW    = (N_ROW > 1) ? $clog2(N_ROW) : 1
) (
  input  logic               clk_l,
  input  logic               rst,
  input  logic               start,
  input  logic [WID_CNT-1:0] cfg_n_beats,
  sblk_act_feeder_if.master  bus,
  output logic [N_ROW-1:0]   row_done,
  output logic               busy
);
  localparam int unsigned BEAT_W = 2 * WID_ACT;
  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam int unsigned CW     = AW + 1;

  typedef enum logic {ST_IDLE, ST_RUN} state_e;

  state_e             state_q, state_d;
  logic [WID_CNT-1:0] n_beats_q, n_beats_d;
  logic [BEAT_W-1:0]  mem_q    [N_ROW][FIFO_DEPTH];
  logic [BEAT_W-1:0]  mem_d    [N_ROW][FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q [N_ROW];
  logic [AW-1:0]      wr_ptr_d [N_ROW];
  logic [AW-1:0]      rd_ptr_q [N_ROW];
  logic [AW-1:0]      rd_ptr_d [N_ROW];
  logic [CW-1:0]      cnt_q    [N_ROW];
  logic [CW-1:0]      cnt_d    [N_ROW];
  logic [WID_CNT-1:0] sent_q   [N_ROW];
  logic [WID_CNT-1:0] sent_d   [N_ROW];
  logic [BEAT_W-1:0]  data_q   [N_ROW];
  logic [BEAT_W-1:0]  data_d   [N_ROW];
  logic [N_ROW-1:0]   vld_q, vld_d;
  logic [N_ROW-1:0]   done_q, done_d;
  logic               busy_q, busy_d;

  logic [N_ROW-1:0]        full_c, empty_c, push_c, pop_c;
  logic                    sel_hit_c, sel_full_c, src_rdy_c;
  logic [BEAT_W*N_ROW-1:0] act_flat_c;

  // FIFO status, host acceptance and per-row push/pop; fullness is pre-pop
  always_comb begin
    full_c     = '0;
    empty_c    = '0;
    push_c     = '0;
    pop_c      = '0;
    sel_hit_c  = 1'b0;
    sel_full_c = 1'b0;
    src_rdy_c  = 1'b0;
    for (int r = 0; r < N_ROW; r++) begin
      full_c[r]  = (cnt_q[r] == CW'(FIFO_DEPTH));
      empty_c[r] = (cnt_q[r] == '0);
      if (bus.src_row == WID_ROW'(r)) begin
        sel_hit_c  = 1'b1;
        sel_full_c = full_c[r];
      end
    end
    if (rst) begin
      src_rdy_c = 1'b0;
    end else if (bus.src_bcast) begin
      src_rdy_c = ~|full_c;
    end else begin
      src_rdy_c = ~sel_hit_c | ~sel_full_c;
    end
    for (int r = 0; r < N_ROW; r++) begin
      push_c[r] = bus.src_vld & src_rdy_c &
                  (bus.src_bcast | (bus.src_row == WID_ROW'(r)));
      pop_c[r]  = (state_q == ST_RUN) & ~start & bus.act_data_in_req[r] &
                  ~empty_c[r] & ~done_q[r];
    end
  end

  // frame control, FIFO bookkeeping and lane beat registers
  always_comb begin
    state_d   = state_q;
    n_beats_d = n_beats_q;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    sent_d    = sent_q;
    data_d    = data_q;
    vld_d     = '0;
    done_d    = done_q;
    busy_d    = 1'b0;

    for (int r = 0; r < N_ROW; r++) begin
      if (push_c[r]) begin
        mem_d[r][wr_ptr_q[r]] = bus.src_data;
        wr_ptr_d[r]           = wr_ptr_q[r] + AW'(1);
      end
      if (pop_c[r]) begin
        data_d[r]   = mem_q[r][rd_ptr_q[r]];
        rd_ptr_d[r] = rd_ptr_q[r] + AW'(1);
        vld_d[r]    = 1'b1;
        sent_d[r]   = sent_q[r] + WID_CNT'(1);
        if ((sent_q[r] + WID_CNT'(1)) == n_beats_q) begin
          done_d[r] = 1'b1;
        end
      end
      cnt_d[r] = cnt_q[r] + CW'(push_c[r]) - CW'(pop_c[r]);
      // a new frame forgets progress but keeps buffered words
      if (start) begin
        sent_d[r] = '0;
        done_d[r] = (cfg_n_beats == '0);
      end
    end

    if (start) begin
      n_beats_d = cfg_n_beats;
      state_d   = ST_RUN;
    end else if ((state_q == ST_RUN) && (&done_d)) begin
      state_d   = ST_IDLE;
    end
    busy_d = (state_d == ST_RUN) && !(&done_d);
  end

  // FIFO storage carries no reset; occupancy is tracked by pointers and counts
  always_ff @(posedge clk_l) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk_l) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      n_beats_q <= '0;
      wr_ptr_q  <= '{default: '0};
      rd_ptr_q  <= '{default: '0};
      cnt_q     <= '{default: '0};
      sent_q    <= '{default: '0};
      data_q    <= '{default: '0};
      vld_q     <= '0;
      done_q    <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_beats_q <= n_beats_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      sent_q    <= sent_d;
      data_q    <= data_d;
      vld_q     <= vld_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    act_flat_c = '0;
    for (int r = 0; r < N_ROW; r++) begin
      act_flat_c[r*BEAT_W +: BEAT_W] = data_q[r];
    end
  end

  assign bus.src_rdy         = src_rdy_c;
  assign bus.act_data_in     = act_flat_c;
  assign bus.act_data_in_vld = vld_q;
  assign row_done            = done_q;
  assign busy                = busy_q;
endmodule

// File: tb/tb_sblk_act_feeder.sv
// Bench for sblk_act_feeder: directed scenarios plus random traffic, all checked
// cycle by cycle against a queue-based frame model.
module tb_sblk_act_feeder;
  localparam int unsigned N_ROW   = 4;
  localparam int unsigned WID_ACT = 16;
  localparam int unsigned FD      = 4;
  localparam int unsigned WID_CNT = 10;
  localparam int unsigned WID_ROW = 3;

  logic               clk_l = 1'b0;
  logic               rst_i = 1'b1;
  logic               start_i = 1'b0;
  logic [WID_CNT-1:0] cfg_i = '0;
  logic [N_ROW-1:0]   row_done;
  logic               busy;

  int n_checks = 0;
  int n_fail   = 0;

  sblk_act_feeder_if #(.N_ROW(N_ROW), .WID_ACT(WID_ACT), .WID_ROW(WID_ROW)) bus ();

  sblk_act_feeder #(
    .N_ROW(N_ROW), .WID_ACT(WID_ACT), .FIFO_DEPTH(FD), .WID_CNT(WID_CNT), .WID_ROW(WID_ROW)
  ) dut (
    .clk_l      (clk_l),
    .rst        (rst_i),
    .start      (start_i),
    .cfg_n_beats(cfg_i),
    .bus        (bus.master),
    .row_done   (row_done),
    .busy       (busy)
  );

  always #5 clk_l = ~clk_l;

  // reference model: word queues per row plus frame progress
  logic [31:0]      mq [N_ROW][$];
  logic [31:0]      e_data [N_ROW] = '{default: '0};
  logic [N_ROW-1:0] e_vld  = '0;
  logic [N_ROW-1:0] e_done = '0;
  logic             e_busy = 1'b0;
  bit               running = 1'b0;
  int               n_beats = 0;
  int               sent [N_ROW] = '{default: 0};

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic m_rdy();
    if (rst_i) return 1'b0;
    if (bus.src_bcast) begin
      for (int r = 0; r < N_ROW; r++) if (mq[r].size() >= FD) return 1'b0;
      return 1'b1;
    end
    if (int'(bus.src_row) >= N_ROW) return 1'b1;
    return mq[int'(bus.src_row)].size() < FD;
  endfunction

  function automatic logic [127:0] flat();
    logic [127:0] f = '0;
    for (int r = 0; r < N_ROW; r++) f[r*32 +: 32] = e_data[r];
    return f;
  endfunction

  task automatic model_step(input logic rdy);
    if (rst_i) begin
      for (int r = 0; r < N_ROW; r++) begin
        mq[r].delete();
        e_data[r] = '0;
        sent[r]   = 0;
      end
      e_vld = '0; e_done = '0; e_busy = 1'b0; running = 1'b0; n_beats = 0;
      return;
    end
    e_vld = '0;
    for (int r = 0; r < N_ROW; r++) begin
      if (running && !start_i && bus.act_data_in_req[r] && mq[r].size() != 0 && !e_done[r]) begin
        e_data[r] = mq[r].pop_front();
        e_vld[r]  = 1'b1;
        sent[r]++;
        if (sent[r] == n_beats) e_done[r] = 1'b1;
      end
    end
    if (bus.src_vld && rdy) begin
      if (bus.src_bcast) begin
        for (int r = 0; r < N_ROW; r++) mq[r].push_back(bus.src_data);
      end else if (int'(bus.src_row) < N_ROW) begin
        mq[int'(bus.src_row)].push_back(bus.src_data);
      end
    end
    if (start_i) begin
      n_beats = int'(cfg_i);
      for (int r = 0; r < N_ROW; r++) sent[r] = 0;
      e_done  = (cfg_i == '0) ? '1 : '0;
      running = 1'b1;
    end
    if (&e_done) running = 1'b0;
    e_busy = running;
  endtask

  // one clock: inputs are already driven just after the falling edge
  task automatic tick();
    logic rdy;
    #1;
    rdy = m_rdy();
    check("src_rdy", bus.src_rdy, rdy);
    model_step(rdy);
    @(posedge clk_l);
    #1;
    check("act_data_in_vld", bus.act_data_in_vld, e_vld);
    check("act_data_in", bus.act_data_in, flat());
    check("row_done", row_done, e_done);
    check("busy", busy, e_busy);
    @(negedge clk_l);
  endtask

  task automatic cyc(input logic r_, input logic st, input logic [WID_CNT-1:0] cfg,
                     input logic v, input logic b, input logic [WID_ROW-1:0] row,
                     input logic [31:0] d, input logic [N_ROW-1:0] req);
    rst_i = r_; start_i = st; cfg_i = cfg;
    bus.src_vld = v; bus.src_bcast = b; bus.src_row = row; bus.src_data = d;
    bus.act_data_in_req = req;
    tick();
  endtask

  task automatic idle(input logic [N_ROW-1:0] req, input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, req);
  endtask

  initial begin
    bus.src_vld = 1'b0; bus.src_bcast = 1'b0; bus.src_row = '0;
    bus.src_data = '0; bus.act_data_in_req = '0;

    // reset with a pending host word, then release
    cyc(1, 0, 0, 1, 0, 0, 32'hDEAD_BEEF, 4'hF);
    cyc(1, 0, 0, 1, 0, 0, 32'hDEAD_BEEF, 4'hF);
    idle(4'h0, 1);

    // unicast streaming to row 2
    for (int i = 1; i <= 4; i++) cyc(0, 0, 0, 1, 0, 3'd2, {16'(i), 16'(i)}, 4'h0);
    cyc(0, 1, 10'd4, 0, 0, 0, 0, 4'b0100);
    idle(4'b0100, 6);

    // broadcast blocked by a full row 0 while unicast to row 1 proceeds
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0, 3'd0, 32'h0A00_0000 + 32'(i), 4'h0);
    cyc(0, 0, 0, 1, 1, 3'd0, 32'hBBBB_BBBB, 4'h0);
    cyc(0, 0, 0, 1, 0, 3'd1, 32'h1111_0001, 4'h0);
    cyc(0, 1, 10'd1, 1, 1, 3'd0, 32'hBBBB_BBBB, 4'b0001);
    cyc(0, 0, 0, 1, 1, 3'd0, 32'hBBBB_BBBB, 4'b0001);
    cyc(0, 0, 0, 1, 1, 3'd0, 32'hBBBB_BBBB, 4'h0);
    idle(4'h0, 2);
    cyc(1, 0, 0, 0, 0, 0, 0, 4'h0);

    // request gating on row 1
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 3'd1, 32'hC000_0000 + 32'(i), 4'h0);
    cyc(0, 1, 10'd3, 0, 0, 0, 0, 4'h0);
    idle(4'b0010, 1); idle(4'b0000, 1); idle(4'b0010, 2); idle(4'h0, 2);
    cyc(1, 0, 0, 0, 0, 0, 0, 4'h0);

    // frame limit of 2 with 3 words buffered, then drain the leftover
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 1, 3'd0, 32'hD000_0000 + 32'(i), 4'h0);
    cyc(0, 1, 10'd2, 0, 0, 0, 0, 4'hF);
    idle(4'hF, 4);
    cyc(0, 1, 10'd1, 0, 0, 0, 0, 4'hF);
    idle(4'hF, 3);

    // zero-beat frame, then out-of-range unicast row
    cyc(0, 0, 0, 1, 1, 3'd0, 32'hE0E0_E0E0, 4'h0);
    cyc(0, 1, 10'd0, 0, 0, 0, 0, 4'hF);
    idle(4'hF, 2);
    cyc(0, 0, 0, 1, 0, 3'd5, 32'h5555_5555, 4'h0);
    cyc(0, 1, 10'd2, 0, 0, 0, 0, 4'h0);
    idle(4'hF, 4);

    // restart after the first beat of a frame
    cyc(1, 0, 0, 0, 0, 0, 0, 4'h0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0, 3'd0, 32'hF000_0000 + 32'(i), 4'h0);
    cyc(0, 1, 10'd3, 0, 0, 0, 0, 4'b0001);
    idle(4'b0001, 1);
    cyc(0, 1, 10'd3, 0, 0, 0, 0, 4'b0001);
    idle(4'b0001, 5);

    // reset in the middle of a frame
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 3'd3, 32'h3300_0000 + 32'(i), 4'h0);
    cyc(0, 1, 10'd3, 0, 0, 0, 0, 4'b1000);
    idle(4'b1000, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 4'b1000);
    cyc(0, 1, 10'd2, 0, 0, 0, 0, 4'b1000);
    idle(4'b1000, 3);

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      logic             r_rst, r_st, r_v, r_b;
      logic [WID_CNT-1:0] r_cfg;
      logic [WID_ROW-1:0] r_row;
      logic [31:0]      r_d;
      logic [N_ROW-1:0] r_req;
      r_rst = ($urandom_range(0, 399) == 0);
      r_st  = ($urandom_range(0, 29) == 0);
      r_cfg = WID_CNT'($urandom_range(0, 5));
      r_v   = ($urandom_range(0, 9) < 7);
      r_b   = ($urandom_range(0, 7) == 0);
      r_row = WID_ROW'($urandom_range(0, 4));
      r_d   = $urandom;
      r_req = N_ROW'($urandom);
      cyc(r_rst, r_st, r_cfg, r_v, r_b, r_row, r_d, r_req);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
